neg_log_iter: RTL and testbench



---
 rtl/neg_log_iter.sv | 151 +++++++++++++++
 tb/tb_neg_log_iter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/neg_log_iter.sv
// Iterative x = -ln(y): y is an unsigned 0.32 fraction, x is returned as 4.16 in bits [19:0].
// Define NEG_LOG_ROUND_EN to add a 21st rounding step; the default build truncates after 20 steps.
module neg_log_iter #(
    parameter int data_size = 32
) (
    input  logic                 clock_i,
    input  logic                 reset_n_i,
    input  logic [data_size-1:0] neg_log_data_i,
    input  logic                 neg_log_data_valid_i,
    output logic                 neg_log_data_ready_o,
    output logic [data_size-1:0] neg_log_data_o,
    output logic                 neg_log_data_valid_o,
    input  logic                 neg_log_data_ready_i
);

`ifdef NEG_LOG_ROUND_EN
    typedef enum logic [1:0] {IDLE, BUSY, ROUND, DONE} stateT;
`else
    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
`endif

    // Hard-wired e^-(2^(idx-16)) in unsigned 0.32.
    function automatic logic [31:0] tableEntry(input logic [4:0] idx);
        logic [31:0] val;
        case (idx)
            5'd19:   val = 32'h0015FC21;
            5'd18:   val = 32'h04B0556E;
            5'd17:   val = 32'h22A55547;
            5'd16:   val = 32'h5E2D58D8;
            5'd15:   val = 32'h9B4597E3;
            5'd14:   val = 32'hC75F7CF5;
            5'd13:   val = 32'hE1EB5127;
            5'd12:   val = 32'hF07D5FDE;
            5'd11:   val = 32'hF81FAB54;
            5'd10:   val = 32'hFC07F55F;
            5'd9:    val = 32'hFE01FEAB;
            5'd8:    val = 32'hFF007FD5;
            5'd7:    val = 32'hFF801FFA;
            5'd6:    val = 32'hFFC007FF;
            5'd5:    val = 32'hFFE001FF;
            5'd4:    val = 32'hFFF0007F;
            5'd3:    val = 32'hFFF8001F;
            5'd2:    val = 32'hFFFC0007;
            5'd1:    val = 32'hFFFE0002;
            5'd0:    val = 32'hFFFF0000;
            default: val = 32'h00000000;
        endcase
        return val;
    endfunction

    stateT       state_q, state_d;
    logic [31:0] yVal_q, yVal_d;
    logic [32:0] prod_q, prod_d;
    logic [19:0] xAcc_q, xAcc_d;
    logic [4:0]  stepIdx_q, stepIdx_d;

    logic [31:0] tableVal;
    logic [64:0] prodFull;
    logic [31:0] cand;
    logic        candGe;
    logic        readyInt;
    logic        validInt;

`ifdef NEG_LOG_ROUND_EN
    assign tableVal = (state_q == ROUND) ? 32'hFFFF8000 : tableEntry(stepIdx_q);
`else
    assign tableVal = tableEntry(stepIdx_q);
`endif

    // p <= 1.0 and T < 1.0, so the shifted product always fits in 32 bits.
    assign prodFull = {32'b0, prod_q} * {33'b0, tableVal};
    assign cand     = prodFull[63:32];
    assign candGe   = (cand >= yVal_q);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= IDLE;
            yVal_q    <= '0;
            prod_q    <= '0;
            xAcc_q    <= '0;
            stepIdx_q <= '0;
        end else begin
            state_q   <= state_d;
            yVal_q    <= yVal_d;
            prod_q    <= prod_d;
            xAcc_q    <= xAcc_d;
            stepIdx_q <= stepIdx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        yVal_d    = yVal_q;
        prod_d    = prod_q;
        xAcc_d    = xAcc_q;
        stepIdx_d = stepIdx_q;
        readyInt  = 1'b0;
        validInt  = 1'b0;
        case (state_q)
            IDLE: begin
                readyInt = 1'b1;
                if (neg_log_data_valid_i) begin
                    yVal_d    = neg_log_data_i;
                    prod_d    = 33'h1_0000_0000;
                    xAcc_d    = '0;
                    stepIdx_d = 5'd19;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (candGe) begin
                    prod_d            = {1'b0, cand};
                    xAcc_d[stepIdx_q] = 1'b1;
                end
                if (stepIdx_q == 5'd0) begin
`ifdef NEG_LOG_ROUND_EN
                    state_d = ROUND;
`else
                    state_d = DONE;
`endif
                end else begin
                    stepIdx_d = stepIdx_q - 5'd1;
                end
            end
`ifdef NEG_LOG_ROUND_EN
            // Half-LSB step: only bumps x, p is no longer needed.
            ROUND: begin
                if (candGe && (xAcc_q != 20'hFFFFF)) begin
                    xAcc_d = xAcc_q + 20'd1;
                end
                state_d = DONE;
            end
`endif
            DONE: begin
                validInt = 1'b1;
                if (neg_log_data_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ready is masked by reset so upstream never sees ready while the block is held.
    assign neg_log_data_ready_o = readyInt & reset_n_i;
    assign neg_log_data_valid_o = validInt;
    assign neg_log_data_o       = validInt ? {12'b0, xAcc_q} : '0;

endmodule

// File: tb/tb_neg_log_iter.sv
// Scoreboard bench for neg_log_iter: directed vectors, backpressure, mid-run reset and a random sweep.
// Build with NEG_LOG_ROUND_EN to check the 21-step rounding variant.
module tb_neg_log_iter;

`ifdef NEG_LOG_ROUND_EN
    localparam int LAT = 21;
`else
    localparam int LAT = 20;
`endif

    typedef struct {
        logic [31:0] expVal;
        int          tol;
        logic [31:0] yIn;
        bit          roundTrip;
    } expT;

    logic        clock_i = 1'b0;
    logic        reset_n_i;
    logic [31:0] neg_log_data_i;
    logic        neg_log_data_valid_i;
    logic        neg_log_data_ready_o;
    logic [31:0] neg_log_data_o;
    logic        neg_log_data_valid_o;
    logic        neg_log_data_ready_i;

    expT     expQ[$];
    longint  acceptQ[$];
    longint  lastHsTime = 0;
    longint  lastAcceptTime = 0;
    int      checksTotal = 0;
    int      checksPassed = 0;
    bit      checkDrop = 0;
    bit      prevValid = 0;

    neg_log_iter #(.data_size(32)) dut (
        .clock_i              (clock_i),
        .reset_n_i            (reset_n_i),
        .neg_log_data_i       (neg_log_data_i),
        .neg_log_data_valid_i (neg_log_data_valid_i),
        .neg_log_data_ready_o (neg_log_data_ready_o),
        .neg_log_data_o       (neg_log_data_o),
        .neg_log_data_valid_o (neg_log_data_valid_o),
        .neg_log_data_ready_i (neg_log_data_ready_i)
    );

    always #5 clock_i = ~clock_i;

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv, input int tol);
        logic [31:0] diff;
        diff = (act > expv) ? act - expv : expv - act;
        checksTotal++;
        if (!$isunknown(act) && (diff <= 32'(tol)))
            checksPassed++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (tol %0d) at %0t",
                     name, act, expv, tol, $time);
    endtask

    // Model: floor(-ln(y) * 2^16), clamped to 20 bits.
    function automatic logic [31:0] modelNegLog(input logic [31:0] y);
        real xr;
        if (y == 32'd0) return 32'h000FFFFF;
        xr = -$ln(real'(y) / 4294967296.0) * 65536.0;
        if (xr >= 1048575.0) return 32'h000FFFFF;
        return 32'(int'($floor(xr)));
    endfunction

    task automatic applyStimulus(input logic [31:0] y, input logic [31:0] expv,
                                 input int tol, input bit rt);
        expT e;
        int  waited;
        @(negedge clock_i);
        neg_log_data_i       = y;
        neg_log_data_valid_i = 1'b1;
        waited = 0;
        while (!neg_log_data_ready_o && waited < 200) begin
            @(negedge clock_i);
            waited++;
        end
        if (!neg_log_data_ready_o) begin
            checkOutput("accept_timeout", 32'(waited), 32'd0, 0);
            neg_log_data_valid_i = 1'b0;
        end else begin
            e.expVal    = expv;
            e.tol       = tol;
            e.yIn       = y;
            e.roundTrip = rt;
            expQ.push_back(e);
            @(posedge clock_i);
            lastAcceptTime = $time;
            acceptQ.push_back($time);
            @(negedge clock_i);
            neg_log_data_valid_i = 1'b0;
            neg_log_data_i       = '0;
        end
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 200) begin
            @(negedge clock_i);
            k++;
        end
        checkOutput("drain_timeout", 32'(expQ.size()), 32'd0, 0);
        @(negedge clock_i);
        @(negedge clock_i);
    endtask

    // Monitor: samples just after each falling edge, pops the scoreboard on handshake.
    initial begin
        expT    e;
        longint ta;
        real    back, rel;
        forever begin
            @(negedge clock_i);
            #1;
            if (checkDrop) begin
                checkOutput("valid_drop", 32'(neg_log_data_valid_o), 32'd0, 0);
                checkOutput("data_zero_idle", neg_log_data_o, 32'd0, 0);
                checkDrop = 0;
            end
            if (neg_log_data_valid_o && !prevValid) begin
                if (acceptQ.size() != 0) begin
                    ta = acceptQ.pop_front();
                    checkOutput("latency", 32'(($time - 6 - ta) / 10), 32'(LAT), 0);
                end else begin
                    checkOutput("unexpected_valid", 32'(neg_log_data_valid_o), 32'd0, 0);
                end
            end
            if (neg_log_data_valid_o) begin
                if (expQ.size() == 0) begin
                    checkOutput("no_expected", 32'(neg_log_data_valid_o), 32'd0, 0);
                end else begin
                    e = expQ[0];
                    if (!neg_log_data_ready_i) begin
                        checkOutput("hold_data", neg_log_data_o, e.expVal, e.tol);
                        checkOutput("ready_o_done", 32'(neg_log_data_ready_o), 32'd0, 0);
                    end else begin
                        checkOutput("result", neg_log_data_o, e.expVal, e.tol);
                        if (e.roundTrip) begin
                            back = $exp(-real'(neg_log_data_o) / 65536.0) * 4294967296.0;
                            rel  = (back - real'(e.yIn)) / real'(e.yIn);
                            if (rel < 0.0) rel = -rel;
                            checkOutput("roundtrip_rel", 32'(int'(rel * 1048576.0)), 32'd0, 256);
                        end
                        void'(expQ.pop_front());
                        lastHsTime = $time + 4;
                        checkDrop  = 1;
                    end
                end
            end
            prevValid = neg_log_data_valid_o;
        end
    end

    initial begin
        logic [31:0] ys   [8];
        logic [31:0] exps [8];
        logic [31:0] y;
        bit          seenValid;

        ys   = '{32'h5E2D58D8, 32'hFFFFFFFF, 32'h00000000, 32'h22A55547,
                 32'h9B4597E3, 32'hF07D5FDE, 32'h00000001, 32'h0015FC21};
        exps = '{32'h00010000, 32'h00000000, 32'h000FFFFF, 32'h00020000,
                 32'h00008000, 32'h00001000, 32'h000FFFFF, 32'h00080000};

        reset_n_i            = 1'b0;
        neg_log_data_i       = '0;
        neg_log_data_valid_i = 1'b0;
        neg_log_data_ready_i = 1'b1;

        repeat (2) @(negedge clock_i);
        #1;
        checkOutput("reset_valid", 32'(neg_log_data_valid_o), 32'd0, 0);
        checkOutput("reset_data", neg_log_data_o, 32'd0, 0);
        checkOutput("reset_ready", 32'(neg_log_data_ready_o), 32'd0, 0);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        @(negedge clock_i);
        #1;
        checkOutput("ready_after_reset", 32'(neg_log_data_ready_o), 32'd1, 0);

        $display("[TB] directed vectors");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(ys[i], exps[i], 0, 0);
            waitDrain();
        end

        $display("[TB] backpressure");
        neg_log_data_ready_i = 1'b0;
        fork
            begin
                for (int k = 0; k < 100 && !neg_log_data_valid_o; k++) @(negedge clock_i);
                repeat (5) @(negedge clock_i);
                neg_log_data_ready_i = 1'b1;
            end
        join_none
        applyStimulus(32'h22A55547, 32'h00020000, 0, 0);
        applyStimulus(32'h9B4597E3, 32'h00008000, 0, 0);
        checkOutput("reaccept_gap", 32'(lastAcceptTime - lastHsTime), 32'd10, 0);
        waitDrain();

        $display("[TB] reset during conversion");
        applyStimulus(32'h5E2D58D8, 32'h00010000, 0, 0);
        repeat (10) @(posedge clock_i);
        #2;
        reset_n_i = 1'b0;
        expQ.delete();
        acceptQ.delete();
        #3;
        checkOutput("midreset_valid", 32'(neg_log_data_valid_o), 32'd0, 0);
        checkOutput("midreset_data", neg_log_data_o, 32'd0, 0);
        checkOutput("midreset_ready", 32'(neg_log_data_ready_o), 32'd0, 0);
        @(negedge clock_i);
        reset_n_i = 1'b1;
        @(negedge clock_i);
        #1;
        checkOutput("ready_after_midreset", 32'(neg_log_data_ready_o), 32'd1, 0);
        seenValid = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock_i);
            if (neg_log_data_valid_o) seenValid = 1;
        end
        checkOutput("no_stale_result", 32'(seenValid), 32'd0, 0);
        applyStimulus(32'h5E2D58D8, 32'h00010000, 0, 0);
        waitDrain();

        $display("[TB] random sweep");
        for (int n = 0; n < 1000; n++) begin
            y = $urandom;
            if (y < 32'h0100_0000) y = y | 32'h0100_0000;
            applyStimulus(y, modelNegLog(y), 2, 1);
            waitDrain();
        end

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
